// File: rtl/collision_detector_pkg.sv
// meikyuu_pkg: VGA 640x480 timing constants, active-window bounds and the
// collision detector state encoding shared across the maze video pipeline.
package meikyuu_pkg;

  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;

  localparam int H_PERIOD = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_PERIOD = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_ACT_FIRST = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    COMMIT     = 2'd2
  } state_t;

  function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_ACT_FIRST) && (h <= H_ACT_LAST) &&
           (v >= V_ACT_FIRST) && (v <= V_ACT_LAST);
  endfunction

endpackage

// File: rtl/collision_detector_if.sv
// collision_detector_if: pixel-stream inputs and per-frame collision results.
interface collision_detector_if;

  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       player_pixel;
  logic       wall_pixel;
  logic       collision;
  logic       frame_done;
  logic [7:0] hit_count;

  modport master (
    output h_counter, v_counter, player_pixel, wall_pixel,
    input  collision, frame_done, hit_count
  );

  modport slave (
    input  h_counter, v_counter, player_pixel, wall_pixel,
    output collision, frame_done, hit_count
  );

endinterface

// File: rtl/collision_detector_sat_counter8.sv
// sat_counter8: 8-bit counter that saturates at 255 with a synchronous clear.
// count_inc is the stored value plus the pending increment, before any clear.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count_inc
);

  logic [7:0] count_r;

  // Saturating add of the pending increment onto the stored count
  always_comb begin
    count_inc = count_r;
    if (inc && (count_r != 8'hFF)) begin
      count_inc = count_r + 8'd1;
    end else begin
      count_inc = count_r;
    end
  end

  // Count register; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else begin
      count_r <= count_inc;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// collision_detector: counts player/wall overlap pixels per VGA frame and flags a
// collision for the next frame. Define COLLISION_HITCOUNT_EN to expose hit_count.
module collision_detector
  import meikyuu_pkg::*;
#(
  parameter int H_TOTAL  = H_PERIOD,
  parameter int V_TOTAL  = V_PERIOD,
  parameter int MIN_HITS = 1
) (
  input logic                 CLOCK_25,
  input logic                 reset,
  collision_detector_if.slave bus
);

  localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [7:0]  MIN_HITS_W = 8'(MIN_HITS);

  state_t     state_r;
  state_t     next_state_s;
  logic       in_range_s;
  logic       first_pixel_s;
  logic       last_pixel_s;
  logic       overlap_s;
  logic       count_en_s;
  logic       commit_s;
  logic [7:0] frame_count_s;
  logic       collision_r;
  logic       frame_done_r;

  assign in_range_s    = ({1'b0, bus.h_counter} < H_TOTAL_W) &&
                         ({1'b0, bus.v_counter} < V_TOTAL_W);
  assign first_pixel_s = (bus.h_counter == 10'd0) && (bus.v_counter == 10'd0);
  assign last_pixel_s  = in_range_s && (bus.h_counter == H_LAST) &&
                         (bus.v_counter == V_LAST);
  assign overlap_s     = in_range_s && in_active(bus.h_counter, bus.v_counter) &&
                         bus.player_pixel && bus.wall_pixel;
  assign count_en_s    = overlap_s && (state_r != WAIT_FRAME);
  // The frame result is taken on the last pixel so it is visible in the COMMIT cycle
  assign commit_s      = (state_r == SCAN) && last_pixel_s;

  sat_counter8 u_hits (
    .clk       (CLOCK_25),
    .rst       (reset),
    .clr       (commit_s),
    .inc       (count_en_s),
    .count_inc (frame_count_s)
  );

  // FSM state register
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_r <= WAIT_FRAME;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      WAIT_FRAME: begin
        if (first_pixel_s) next_state_s = SCAN;
        else               next_state_s = WAIT_FRAME;
      end
      SCAN: begin
        if (last_pixel_s) next_state_s = COMMIT;
        else              next_state_s = SCAN;
      end
      COMMIT:  next_state_s = SCAN;
      default: next_state_s = WAIT_FRAME;
    endcase
  end

  // Frame result registers, held until the next commit
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      collision_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= commit_s;
      if (commit_s) begin
        collision_r <= (frame_count_s >= MIN_HITS_W);
      end else begin
        collision_r <= collision_r;
      end
    end
  end

  assign bus.collision  = collision_r;
  assign bus.frame_done = frame_done_r;

`ifdef COLLISION_HITCOUNT_EN
  logic [7:0] hit_count_r;

  // Committed overlap count
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      hit_count_r <= 8'd0;
    end else if (commit_s) begin
      hit_count_r <= frame_count_s;
    end else begin
      hit_count_r <= hit_count_r;
    end
  end

  assign bus.hit_count = hit_count_r;
`else
  assign bus.hit_count = 8'd0;
`endif

endmodule
